// File: rtl/dds_sine_source.sv
// dds_sine_source: phase accumulator plus quarter-wave sine/cosine lookup for the DDS chain.
// One {cos, sin} sample pair per PWM period, delivered with a one-cycle o_ce strobe.
// Tuning words arrive over a valid/ready handshake and take effect only on sample ticks.
// Optional build macro DDS_PHASE_DITHER_EN adds LFSR dither to the lookup phase.
module dds_sine_source #(
  parameter int unsigned ROM_WIDTH     = 8,
  parameter int unsigned PHASE_WIDTH   = 24,
  parameter int unsigned LUT_ADDR      = 8,
  parameter int unsigned KPERIOD_COUNT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic [PHASE_WIDTH-1:0]   i_ftw,
  input  logic                     i_ftw_valid,
  output logic                     o_ftw_ready,
  input  logic                     i_phase_rst,
  output logic                     o_ce,
  output logic [2*ROM_WIDTH-1:0]   o_data,
  output logic [PHASE_WIDTH-1:0]   o_phase
);

  localparam int unsigned PW       = PHASE_WIDTH;
  localparam int unsigned RW       = ROM_WIDTH;
  localparam int unsigned LUT_SIZE = 1 << LUT_ADDR;
  localparam int unsigned IW       = LUT_ADDR + 2;
  localparam int unsigned TRUNC    = PW - 2 - LUT_ADDR;
  localparam int unsigned CW       = (KPERIOD_COUNT > 0) ? $clog2(KPERIOD_COUNT + 1) : 1;
  localparam logic [RW-1:0] MID    = RW'(1 << (RW - 1));
  localparam logic [RW-1:0] MID_M1 = RW'((1 << (RW - 1)) - 1);

  // Rounded quarter-wave entry, computed at elaboration with a Q30 Taylor series.
  function automatic logic [ROM_WIDTH-1:0] lut_entry(input int unsigned k);
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint amp;
    x    = (64'sd1686629713 * longint'(2 * k + 1)) >>> (LUT_ADDR + 1);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 7; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      acc  = acc + term;
    end
    amp = longint'((1 << (ROM_WIDTH - 1)) - 1);
    return ROM_WIDTH'((amp * acc + 64'sd536870912) >>> 30);
  endfunction

  // Mirror the table address in odd quadrants.
  function automatic logic [LUT_ADDR-1:0] fold(input logic [IW-1:0] idx);
    return idx[LUT_ADDR] ? ~idx[LUT_ADDR-1:0] : idx[LUT_ADDR-1:0];
  endfunction

  // Map a table magnitude onto offset binary, negated in the lower half-wave.
  function automatic logic [RW-1:0] to_offset(input logic [RW-1:0] v, input logic neg);
    return neg ? (MID_M1 - v) : (MID + v);
  endfunction

  logic [RW-1:0] lut [LUT_SIZE];

  for (genvar k = 0; k < LUT_SIZE; k++) begin : g_lut
    localparam logic [RW-1:0] ENTRY = lut_entry(k);
    assign lut[k] = ENTRY;
  end

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = i_en && (cnt == CW'(KPERIOD_COUNT));

  // Sample-period counter; holds while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= (cnt == CW'(KPERIOD_COUNT)) ? '0 : cnt + CW'(1);
    end
  end

  logic [PW-1:0] phase;
  logic [PW-1:0] ftw_active;
  logic [PW-1:0] ftw_pend;
  logic          pend_valid;
  logic          pend_next;
  logic          xfer;

  assign xfer = i_ftw_valid && o_ftw_ready;

  // Pending-word occupancy: cleared when a tick consumes it, set by a new transfer.
  always_comb begin
    pend_next = pend_valid;
    if (tick && pend_valid) pend_next = 1'b0;
    if (xfer) pend_next = 1'b1;
  end

  // Accumulator and tuning-word handshake; a word accepted on a tick waits for the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= '0;
      ftw_active  <= '0;
      ftw_pend    <= '0;
      pend_valid  <= 1'b0;
      o_ftw_ready <= 1'b0;
    end else begin
      if (tick) begin
        phase <= i_phase_rst ? '0 : phase + ftw_active;
        if (pend_valid) ftw_active <= ftw_pend;
      end
      if (xfer) ftw_pend <= i_ftw;
      pend_valid  <= pend_next;
      o_ftw_ready <= ~pend_next;
    end
  end

  logic [PW-1:0] lk_phase;

`ifdef DDS_PHASE_DITHER_EN
  localparam int unsigned DMASK = (32'd1 << TRUNC) - 32'd1;

  logic [15:0] lfsr;

  // Fibonacci LFSR (taps 16,14,13,11) stepped once per sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (tick) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign lk_phase = phase + PW'(32'(lfsr) & DMASK);
`else
  assign lk_phase = phase;
`endif

  logic [IW-1:0] idx_s;
  logic [IW-1:0] idx_c;

  assign idx_s = IW'(lk_phase >> TRUNC);
  assign idx_c = idx_s + IW'(LUT_SIZE);

  logic [LUT_ADDR-1:0] addr_s;
  logic [LUT_ADDR-1:0] addr_c;
  logic                neg_s2;
  logic                neg_c2;
  logic                neg_s3;
  logic                neg_c3;
  logic [PW-1:0]       phase2;
  logic [PW-1:0]       phase3;
  logic [RW-1:0]       rom_s;
  logic [RW-1:0]       rom_c;

  // Lookup datapath: address/quadrant stage, then ROM read stage.
  always_ff @(posedge clk) begin
    addr_s <= fold(idx_s);
    addr_c <= fold(idx_c);
    neg_s2 <= idx_s[IW-1];
    neg_c2 <= idx_c[IW-1];
    phase2 <= phase;
    rom_s  <= lut[addr_s];
    rom_c  <= lut[addr_c];
    neg_s3 <= neg_s2;
    neg_c3 <= neg_c2;
    phase3 <= phase2;
  end

  logic v1;
  logic v2;
  logic v3;

  // Sample valid pipeline and output register; reset drops in-flight samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      o_ce    <= 1'b0;
      o_data  <= {MID, MID};
      o_phase <= '0;
    end else begin
      v1   <= tick;
      v2   <= v1;
      v3   <= v2;
      o_ce <= v3;
      if (v3) begin
        o_data  <= {to_offset(rom_c, neg_c3), to_offset(rom_s, neg_s3)};
        o_phase <= phase3;
      end
    end
  end

endmodule

// File: tb/tb_dds_sine_source.sv
// Directed bench for dds_sine_source with a 4-cycle sample period.
module tb_dds_sine_source;

  localparam int unsigned PW   = 24;
  localparam int unsigned RW   = 8;
  localparam int unsigned STEP = 32'h100000;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [PW-1:0] ftw;
  logic          ftw_valid;
  logic          ftw_ready;
  logic          phase_rst;
  logic          ce;
  logic [2*RW-1:0] data;
  logic [PW-1:0] phase;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dds_sine_source #(
    .ROM_WIDTH(8),
    .PHASE_WIDTH(24),
    .LUT_ADDR(8),
    .KPERIOD_COUNT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_en(en),
    .i_ftw(ftw),
    .i_ftw_valid(ftw_valid),
    .o_ftw_ready(ftw_ready),
    .i_phase_rst(phase_rst),
    .o_ce(ce),
    .o_data(data),
    .o_phase(phase)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ce(input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (ce !== 1'b1 && n < maxc);
  endtask

  task automatic no_ce(input string tag, input int cycles);
    int seen = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (ce !== 1'b0) seen++;
    end
    chk(tag, 64'(seen), 64'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; ftw = '0; ftw_valid = 1'b0; phase_rst = 1'b0;

    // reset state
    repeat (3) step();
    chk("rst_data", 64'(data), 64'h8080);
    chk("rst_ce", 64'(ce), 64'(0));
    chk("rst_phase", 64'(phase), 64'(0));
    chk("rst_ready_low", 64'(ftw_ready), 64'(0));
    rst = 1'b0;
    step();
    chk("ready_after_rst", 64'(ftw_ready), 64'(1));
    no_ce("idle_no_ce", 10);

    // load first word, then enable
    ftw = 24'h100000; ftw_valid = 1'b1;
    step();
    chk("load_ready_fall", 64'(ftw_ready), 64'(0));
    ftw_valid = 1'b0; en = 1'b1;
    wait_ce(20, n);
    chk("first_latency", 64'(n), 64'(7));
    chk("first_phase", 64'(phase), 64'(0));
    chk("first_data", 64'(data), 64'hFF80);

    // cadence over one full waveform period
    for (int i = 1; i <= 16; i++) begin
      wait_ce(20, n);
      chk($sformatf("cadence_%0d", i), 64'(n), 64'(4));
      chk($sformatf("phase_%0d", i), 64'(phase), 64'(24'(i * STEP)));
      case (i)
        1:  chk("data_1", 64'(data), 64'hF5B1);
        4:  chk("data_4", 64'(data), 64'h7FFF);
        8:  chk("data_8", 64'(data), 64'h007F);
        12: chk("data_12", 64'(data), 64'h8000);
        16: chk("data_16", 64'(data), 64'hFF80);
        default: ;
      endcase
    end

    // handshake: word mid-period, second word stalls
    step();
    ftw = 24'h200000; ftw_valid = 1'b1;
    step();
    chk("hs_ready_fall", 64'(ftw_ready), 64'(0));
    ftw = 24'h300000;
    step();
    chk("hs_stall", 64'(ftw_ready), 64'(0));
    step();
    chk("hs_ce_t0", 64'(ce), 64'(1));
    chk("hs_phase_t0", 64'(phase), 64'h100000);
    step();
    chk("hs_ready_back", 64'(ftw_ready), 64'(1));
    chk("hold_data", 64'(data), 64'hF5B1);
    chk("hold_ce", 64'(ce), 64'(0));
    step();
    ftw_valid = 1'b0;
    chk("hs_second_taken", 64'(ftw_ready), 64'(0));
    wait_ce(20, n);
    chk("hs_gap", 64'(n), 64'(2));
    chk("hs_old_step", 64'(phase), 64'h200000);
    wait_ce(20, n);
    chk("hs_new_step", 64'(phase), 64'h400000);
    wait_ce(20, n);
    chk("hs_second_step", 64'(phase), 64'h700000);

    // collision: word offered in the tick cycle
    chk("col_ready", 64'(ftw_ready), 64'(1));
    ftw = 24'h010000; ftw_valid = 1'b1;
    step();
    ftw_valid = 1'b0;
    chk("col_taken", 64'(ftw_ready), 64'(0));
    wait_ce(20, n);
    chk("col_gap", 64'(n), 64'(3));
    chk("col_old", 64'(phase), 64'hA00000);
    wait_ce(20, n);
    chk("col_still_old", 64'(phase), 64'hD00000);
    wait_ce(20, n);
    chk("col_new", 64'(phase), 64'hD10000);

    // phase reset on a tick, then off-tick pulse
    phase_rst = 1'b1;
    step();
    phase_rst = 1'b0;
    wait_ce(20, n);
    chk("prst_phase", 64'(phase), 64'(0));
    chk("prst_data", 64'(data), 64'hFF80);
    step();
    phase_rst = 1'b1;
    step();
    phase_rst = 1'b0;
    wait_ce(20, n);
    chk("prst_next", 64'(phase), 64'h010000);
    wait_ce(20, n);
    chk("prst_offtick", 64'(phase), 64'h020000);

    // enable gating one cycle after a tick
    step();
    en = 1'b0;
    wait_ce(20, n);
    chk("gate_drain_gap", 64'(n), 64'(3));
    chk("gate_drain_phase", 64'(phase), 64'h030000);
    no_ce("gate_idle", 12);
    en = 1'b1;
    wait_ce(20, n);
    chk("resume_latency", 64'(n), 64'(7));
    chk("resume_phase", 64'(phase), 64'h040000);
    wait_ce(20, n);
    chk("resume_phase2", 64'(phase), 64'h050000);

    // gate with the counter held at 2
    repeat (3) step();
    en = 1'b0;
    wait_ce(20, n);
    chk("held_drain_gap", 64'(n), 64'(1));
    chk("held_drain_phase", 64'(phase), 64'h060000);
    no_ce("held_idle", 8);
    en = 1'b1;
    wait_ce(20, n);
    chk("resume_held_cnt", 64'(n), 64'(5));
    chk("resume_held_phase", 64'(phase), 64'h070000);

    // reset two cycles after a tick drops the in-flight sample
    step();
    step();
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0;
    chk("mid_rst_data", 64'(data), 64'h8080);
    chk("mid_rst_phase", 64'(phase), 64'(0));
    chk("mid_rst_ce", 64'(ce), 64'(0));
    chk("mid_rst_ready", 64'(ftw_ready), 64'(0));
    no_ce("mid_rst_no_ce", 10);
    chk("mid_rst_ready_back", 64'(ftw_ready), 64'(1));
    en = 1'b1;
    wait_ce(20, n);
    chk("post_rst_latency", 64'(n), 64'(7));
    chk("post_rst_phase", 64'(phase), 64'(0));
    chk("post_rst_data", 64'(data), 64'hFF80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
